// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus: raw pins and software clears in, debounced level,
// edge pulses and sticky change flags out.
interface sw_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] chg_clr;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic [WIDTH-1:0] chg_sticky;

  // Side that owns the pins and the clear strobes (board / software logic).
  modport master (
    output sw_raw,
    output chg_clr,
    input  sw_stable,
    input  sw_rise,
    input  sw_fall,
    input  chg_sticky
  );

  // Side implemented by the debouncer.
  modport slave (
    input  sw_raw,
    input  chg_clr,
    output sw_stable,
    output sw_rise,
    output sw_fall,
    output chg_sticky
  );
endinterface

// File: rtl/sw_debounce.sv
// Per-channel slide-switch conditioner: two-flop synchronizer, consecutive-
// cycle debounce counter, debounced level, registered rise/fall pulses and
// software-clearable sticky change flags. Every output comes from a flop.
module sw_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic         clk,
  input  logic         rst,
  sw_debounce_if.slave bus
);

  // Terminal count: a level is accepted on the edge where the counter already
  // holds DEBOUNCE_CYCLES-1, so the counter never exceeds this value and
  // CNT_W only has to represent DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_sticky;

  // Two-flop synchronizer for the asynchronous pins; nothing sits between the flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CNT_W-1:0] r_cnt;
      logic             r_stable;
      logic             r_rise;
      logic             r_fall;
      logic             r_sticky;
      logic             w_differ;
      logic             w_accept;

      assign w_differ = r_sync2[gi] ^ r_stable;
      assign w_accept = w_differ && (r_cnt == CNT_LAST);

      // Count consecutive differing cycles; any agreement or an acceptance restarts from zero.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (!w_differ || w_accept) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      // Take the new level on acceptance, emit a one-cycle edge pulse, and latch the sticky flag (set beats clear).
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stable <= 1'b0;
          r_rise   <= 1'b0;
          r_fall   <= 1'b0;
          r_sticky <= 1'b0;
        end else begin
          if (w_accept) begin
            r_stable <= r_sync2[gi];
          end
          r_rise <= w_accept & r_sync2[gi];
          r_fall <= w_accept & ~r_sync2[gi];
          if (w_accept) begin
            r_sticky <= 1'b1;
          end else if (bus.chg_clr[gi]) begin
            r_sticky <= 1'b0;
          end
        end
      end

      assign w_stable[gi] = r_stable;
      assign w_rise[gi]   = r_rise;
      assign w_fall[gi]   = r_fall;
      assign w_sticky[gi] = r_sticky;
    end
  endgenerate

  assign bus.sw_stable  = w_stable;
  assign bus.sw_rise    = w_rise;
  assign bus.sw_fall    = w_fall;
  assign bus.chg_sticky = w_sticky;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios plus randomized switch activity,
// checked against a window-based reference model of the debounce rules.
module tb_sw_debounce;
  localparam int W  = 8;
  localparam int DC = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sw_debounce_if #(.WIDTH(W)) bus ();

  sw_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: a change is accepted on an edge when the synchronized
  // level seen on that edge and on the DC-1 edges before it all differ from
  // the current stable level.
  logic [W-1:0] m_raw1, m_raw2;
  logic [W-1:0] m_stable, m_rise, m_fall, m_sticky;
  logic [W-1:0] m_hist [DC-1];
  int           m_nhist;

  function automatic logic [W-1:0] model_accept();
    logic [W-1:0] acc;
    acc = m_raw2 ^ m_stable;
    if (m_nhist < DC - 1) acc = '0;
    for (int j = 0; j < DC - 1; j++) acc = acc & (m_hist[j] ^ m_stable);
    return acc;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_raw1   <= '0;
      m_raw2   <= '0;
      m_stable <= '0;
      m_rise   <= '0;
      m_fall   <= '0;
      m_sticky <= '0;
      m_nhist  <= 0;
      for (int j = 0; j < DC - 1; j++) m_hist[j] <= '0;
    end else begin
      m_raw1   <= bus.sw_raw;
      m_raw2   <= m_raw1;
      m_hist[0] <= m_raw2;
      for (int j = 1; j < DC - 1; j++) m_hist[j] <= m_hist[j-1];
      m_nhist  <= (m_nhist < DC - 1) ? m_nhist + 1 : m_nhist;
      m_stable <= m_stable ^ model_accept();
      m_rise   <= model_accept() & m_raw2;
      m_fall   <= model_accept() & ~m_raw2;
      m_sticky <= model_accept() | (m_sticky & ~bus.chg_clr);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    $display("test_reset");
    bus.sw_raw  = '1;
    bus.chg_clr = '0;
    #1 rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.chg_sticky} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%h/%h/%h want all zero",
               bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.chg_sticky);
    end
    rst = 1'b0;
    bus.sw_raw = '0;
  endtask

  task automatic test_rise_latency();
    logic [W-1:0] exp_st, exp_r;
    $display("test_rise_latency");
    bus.sw_raw = 8'h01;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_st = (n >= 6) ? 8'h01 : 8'h00;
      exp_r  = (n == 6) ? 8'h01 : 8'h00;
      checks++;
      if (bus.sw_stable !== exp_st || bus.sw_rise !== exp_r || bus.chg_sticky !== exp_st) begin
        errors++;
        $display("FAIL rise_latency edge=%0d got st=%h rise=%h sticky=%h want st=%h rise=%h sticky=%h",
                 n, bus.sw_stable, bus.sw_rise, bus.chg_sticky, exp_st, exp_r, exp_st);
      end
    end
  endtask

  task automatic test_bounce();
    logic [W-1:0] exp_st, exp_r;
    $display("test_bounce");
    for (int p = 0; p < 4; p++) begin
      bus.sw_raw = (p % 2 == 0) ? 8'h03 : 8'h01;
      repeat (2) begin
        tick();
        checks++;
        if (bus.sw_rise !== 8'h00 || bus.sw_fall !== 8'h00 || bus.sw_stable !== 8'h01) begin
          errors++;
          $display("FAIL bounce_reject phase=%0d got st=%h rise=%h fall=%h want st=01 rise=00 fall=00",
                   p, bus.sw_stable, bus.sw_rise, bus.sw_fall);
        end
      end
    end
    bus.sw_raw = 8'h03;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_st = (n >= 6) ? 8'h03 : 8'h01;
      exp_r  = (n == 6) ? 8'h02 : 8'h00;
      checks++;
      if (bus.sw_stable !== exp_st || bus.sw_rise !== exp_r) begin
        errors++;
        $display("FAIL bounce_settle edge=%0d got st=%h rise=%h want st=%h rise=%h",
                 n, bus.sw_stable, bus.sw_rise, exp_st, exp_r);
      end
    end
  endtask

  task automatic test_multi_fall();
    logic [W-1:0] exp_st, exp_f;
    $display("test_multi_fall");
    bus.sw_raw = 8'hFF;
    repeat (6) tick();
    checks++;
    if (bus.sw_stable !== 8'hFF || bus.sw_rise !== 8'hFC) begin
      errors++;
      $display("FAIL multi_rise got st=%h rise=%h want st=ff rise=fc", bus.sw_stable, bus.sw_rise);
    end
    bus.sw_raw = 8'h5A;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_st = (n >= 6) ? 8'h5A : 8'hFF;
      exp_f  = (n == 6) ? 8'hA5 : 8'h00;
      checks++;
      if (bus.sw_stable !== exp_st || bus.sw_fall !== exp_f || bus.sw_rise !== 8'h00) begin
        errors++;
        $display("FAIL multi_fall edge=%0d got st=%h fall=%h rise=%h want st=%h fall=%h rise=00",
                 n, bus.sw_stable, bus.sw_fall, bus.sw_rise, exp_st, exp_f);
      end
    end
  endtask

  task automatic test_sticky();
    $display("test_sticky");
    checks++;
    if (bus.chg_sticky !== 8'hFF) begin
      errors++;
      $display("FAIL sticky_accum got %h want ff", bus.chg_sticky);
    end
    bus.chg_clr = 8'h01;
    tick();
    bus.chg_clr = 8'h00;
    checks++;
    if (bus.chg_sticky !== 8'hFE) begin
      errors++;
      $display("FAIL sticky_clr0 got %h want fe", bus.chg_sticky);
    end
    tick();
    checks++;
    if (bus.chg_sticky !== 8'hFE) begin
      errors++;
      $display("FAIL sticky_hold got %h want fe", bus.chg_sticky);
    end
    bus.chg_clr = 8'hFF;
    tick();
    bus.chg_clr = 8'h00;
    checks++;
    if (bus.chg_sticky !== 8'h00) begin
      errors++;
      $display("FAIL sticky_clr_all got %h want 00", bus.chg_sticky);
    end
    bus.sw_raw = 8'h5E;
    repeat (5) tick();
    bus.chg_clr = 8'h04;
    tick();
    bus.chg_clr = 8'h00;
    checks++;
    if (bus.chg_sticky !== 8'h04 || bus.sw_rise !== 8'h04) begin
      errors++;
      $display("FAIL sticky_set_wins got sticky=%h rise=%h want sticky=04 rise=04",
               bus.chg_sticky, bus.sw_rise);
    end
    tick();
    checks++;
    if (bus.chg_sticky !== 8'h04) begin
      errors++;
      $display("FAIL sticky_after_set got %h want 04", bus.chg_sticky);
    end
  endtask

  task automatic test_reset_mid_count();
    logic [W-1:0] exp_st, exp_r;
    $display("test_reset_mid_count");
    bus.sw_raw = 8'h08;
    repeat (6) tick();
    checks++;
    if (bus.sw_stable !== 8'h08) begin
      errors++;
      $display("FAIL mid_setup got st=%h want 08", bus.sw_stable);
    end
    bus.sw_raw = 8'h00;
    repeat (4) tick();
    checks++;
    if (bus.sw_stable !== 8'h08) begin
      errors++;
      $display("FAIL mid_counting got st=%h want 08", bus.sw_stable);
    end
    bus.sw_raw = 8'h08;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.chg_sticky} !== '0) begin
      errors++;
      $display("FAIL async_reset got %h/%h/%h/%h want all zero before next edge",
               bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.chg_sticky);
    end
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_st = (n >= 6) ? 8'h08 : 8'h00;
      exp_r  = (n == 6) ? 8'h08 : 8'h00;
      checks++;
      if (bus.sw_stable !== exp_st || bus.sw_rise !== exp_r) begin
        errors++;
        $display("FAIL post_reset_rise edge=%0d got st=%h rise=%h want st=%h rise=%h",
                 n, bus.sw_stable, bus.sw_rise, exp_st, exp_r);
      end
      checks++;
      if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.chg_sticky} !==
          {m_stable, m_rise, m_fall, m_sticky}) begin
        errors++;
        $display("FAIL post_reset_model edge=%0d got %h/%h/%h/%h want %h/%h/%h/%h", n,
                 bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.chg_sticky,
                 m_stable, m_rise, m_fall, m_sticky);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] tog;
    $display("test_random");
    for (int c = 0; c < 600; c++) begin
      tog = '0;
      for (int b = 0; b < W; b++) if ($urandom_range(0, 5) == 0) tog[b] = 1'b1;
      bus.sw_raw  = bus.sw_raw ^ tog;
      bus.chg_clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      tick();
      checks++;
      if ({bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.chg_sticky} !==
          {m_stable, m_rise, m_fall, m_sticky}) begin
        errors++;
        $display("FAIL random_model cycle=%0d got %h/%h/%h/%h want %h/%h/%h/%h", c,
                 bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.chg_sticky,
                 m_stable, m_rise, m_fall, m_sticky);
      end
      checks++;
      if ((bus.sw_rise & bus.sw_fall) !== '0) begin
        errors++;
        $display("FAIL random_rise_and_fall cycle=%0d got overlap %h want 00", c,
                 bus.sw_rise & bus.sw_fall);
      end
    end
    bus.chg_clr = '0;
  endtask

  initial begin
    bus.sw_raw  = '0;
    bus.chg_clr = '0;
    @(negedge clk);
    test_reset();
    test_rise_latency();
    test_bounce();
    test_multi_fall();
    test_sticky();
    test_reset_mid_count();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
